mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port.sv | 145 ++++++++++++++
 tb/tb_mem_port.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// Memory port for the multicycle core: one outstanding access at a time,
// with a fetch/data address mux, an IR/MDR capture path and a wait timeout.
module mem_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  // Last counter value before the wait budget is exhausted.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_q;
  logic        iord_q;
  logic        irw_q;
  logic [31:0] addr;
  logic        misal;
  logic        expire;

  assign addr   = IorD ? alu_out : pc;
  assign misal  = |addr[1:0];
  assign expire = (wait_q == LAST);

  assign Op    = ir[31:26];
  assign Funct = ir[5:0];
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = misal ? ERR : REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
        end else if (expire) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      wait_q    <= '0;
      iord_q    <= 1'b0;
      irw_q     <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            iord_q    <= IorD;
            irw_q     <= IRWrite;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            wait_q    <= '0;
            if (misal) begin
              fault <= 1'b1;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= MemWrite;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            // Stores never touch IR/MDR; fetches only with IRWrite.
            if (!mem_we) begin
              if (iord_q) begin
                mdr <= mem_rdata;
              end else if (irw_q) begin
                ir <= mem_rdata;
              end
            end
          end else if (expire) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            fault   <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Scoreboard bench for mem_port: expected IR/MDR/outcome queued at
// start, popped when done or fault appears.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        IorD;
  logic        MemWrite;
  logic        IRWrite;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        busy;
  logic        done;
  logic        fault;

  always #5 clk = ~clk;

  mem_port #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .ir        (ir),
    .mdr       (mdr),
    .Op        (Op),
    .Funct     (Funct),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  typedef struct {
    logic        flt;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  typedef struct {
    logic        iord;
    logic        mw;
    logic        irw;
    logic [31:0] pv;
    logic [31:0] av;
    logic [31:0] wd;
    logic [31:0] rd;
    int          w;
  } vec_t;

  exp_t        sbq[$];
  logic [31:0] m_ir;
  logic [31:0] m_mdr;
  int          checks;
  int          errors;

  task automatic step();
    @(negedge clk);
  endtask

  // Issues one access at a negedge in IDLE; returns cycles from start
  // to done/fault and whether the request was held correctly.
  task automatic drive_access(
    input  logic        iord,
    input  logic        mw,
    input  logic        irw,
    input  logic [31:0] pv,
    input  logic [31:0] av,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          waits,
    output int          lat,
    output logic        hold_ok
  );
    logic [31:0] a;
    exp_t        e;
    a      = iord ? av : pv;
    e.flt  = (a[1:0] != 2'b00);
    e.ir   = m_ir;
    e.mdr  = m_mdr;
    if (!e.flt && !mw) begin
      if (iord) e.mdr = rd;
      else if (irw) e.ir = rd;
    end
    m_ir  = e.ir;
    m_mdr = e.mdr;
    sbq.push_back(e);
    IorD = iord; MemWrite = mw; IRWrite = irw;
    pc = pv; alu_out = av; wdata = wd;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    hold_ok = 1'b1;
    pc = ~pv; alu_out = ~av; wdata = ~wd;
    IorD = ~iord; MemWrite = ~mw; IRWrite = ~irw;
    if (e.flt) begin
      hold_ok = !mem_req;
    end else begin
      for (int i = 0; i <= waits; i++) begin
        if (!(mem_req && mem_addr == a && mem_we == mw && mem_wdata == wd))
          hold_ok = 1'b0;
        if (i == waits) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        step();
        lat++;
      end
      mem_ack = 1'b0;
      mem_rdata = 32'hA5A5_5A5A;
    end
    while (!(done || fault) && lat < waits + 8) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mem_ack = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_req req=%b we=%b want 0 0", mem_req, mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if (ir !== 32'h0 || mdr !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs ir=%h mdr=%h want 0", ir, mdr);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b fault=%b want 0", busy, done, fault);
    end
    start = 1'b0; mem_ack = 1'b0;
    step();
    rst = 1'b0;
    m_ir = '0;
    m_mdr = '0;
    step();
  endtask

  task automatic test_fetch();
    int   lat;
    logic hold;
    exp_t e;
    drive_access(1'b0, 1'b0, 1'b1, 32'h40, 32'h999, 32'h0,
                 32'h8C43_0004, 3, lat, hold);
    e = sbq.pop_front();
    checks++;
    if (done !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done done=%b fault=%b want 1 0", done, fault);
    end
    checks++;
    if (ir !== e.ir || mdr !== e.mdr) begin
      errors++;
      $display("FAIL fetch_regs ir=%h mdr=%h want %h %h", ir, mdr, e.ir, e.mdr);
    end
    checks++;
    if (Op !== 6'h23 || Funct !== 6'h04) begin
      errors++;
      $display("FAIL fetch_op Op=%h Funct=%h want 23 04", Op, Funct);
    end
    checks++;
    if (lat !== 5 || !hold) begin
      errors++;
      $display("FAIL fetch_timing lat=%0d hold=%b want 5 1", lat, hold);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_end done=%b busy=%b req=%b want 0", done, busy, mem_req);
    end
  endtask

  task automatic test_load();
    int   lat;
    logic hold;
    exp_t e;
    drive_access(1'b1, 1'b0, 1'b0, 32'h44, 32'h100, 32'h0,
                 32'hDEAD_BEEF, 0, lat, hold);
    e = sbq.pop_front();
    checks++;
    if (done !== 1'b1 || mdr !== e.mdr || ir !== e.ir) begin
      errors++;
      $display("FAIL load done=%b ir=%h mdr=%h want 1 %h %h", done, ir, mdr, e.ir, e.mdr);
    end
    checks++;
    if (lat !== 2 || !hold) begin
      errors++;
      $display("FAIL load_timing lat=%0d hold=%b want 2 1", lat, hold);
    end
    step();
  endtask

  task automatic test_store();
    int   lat;
    logic hold;
    exp_t e;
    drive_access(1'b1, 1'b1, 1'b1, 32'h48, 32'h10C, 32'h1234_5678,
                 32'hFFFF_FFFF, 2, lat, hold);
    e = sbq.pop_front();
    checks++;
    if (done !== 1'b1 || ir !== e.ir || mdr !== e.mdr) begin
      errors++;
      $display("FAIL store done=%b ir=%h mdr=%h want 1 %h %h", done, ir, mdr, e.ir, e.mdr);
    end
    checks++;
    if (lat !== 4 || !hold || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL store_bus lat=%0d hold=%b we=%b want 4 1 0", lat, hold, mem_we);
    end
    step();
  endtask

  task automatic test_misaligned();
    int   lat;
    logic hold;
    exp_t e;
    drive_access(1'b1, 1'b0, 1'b0, 32'h40, 32'h102, 32'h0,
                 32'h1357_9BDF, 0, lat, hold);
    e = sbq.pop_front();
    checks++;
    if (fault !== 1'b1 || done !== 1'b0 || lat !== 1 || !hold) begin
      errors++;
      $display("FAIL misalign fault=%b done=%b lat=%0d noreq=%b want 1 0 1 1", fault, done, lat, hold);
    end
    checks++;
    if (ir !== e.ir || mdr !== e.mdr) begin
      errors++;
      $display("FAIL misalign_regs ir=%h mdr=%h want %h %h", ir, mdr, e.ir, e.mdr);
    end
    step();
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL misalign_end busy=%b req=%b fault=%b want 0", busy, mem_req, fault);
    end
  endtask

  task automatic test_timeout();
    int   req_cnt;
    int   k;
    int   lat;
    logic hold;
    exp_t e;
    e.flt = 1'b1; e.ir = m_ir; e.mdr = m_mdr;
    sbq.push_back(e);
    IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b1; pc = 32'h80;
    start = 1'b1;
    step();
    start = 1'b0;
    req_cnt = 0;
    k = 0;
    while (!fault && k < 20) begin
      if (mem_req) req_cnt++;
      step();
      k++;
    end
    e = sbq.pop_front();
    checks++;
    if (fault !== 1'b1 || k !== 4 || req_cnt !== 4) begin
      errors++;
      $display("FAIL timeout fault=%b at=%0d req_cycles=%0d want 1 4 4", fault, k, req_cnt);
    end
    checks++;
    if (ir !== e.ir || mdr !== e.mdr || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regs ir=%h mdr=%h req=%b", ir, mdr, mem_req);
    end
    step();
    drive_access(1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0,
                 32'h0BAD_F00D, 1, lat, hold);
    e = sbq.pop_front();
    checks++;
    if (done !== 1'b1 || mdr !== e.mdr || lat !== 3) begin
      errors++;
      $display("FAIL timeout_recover done=%b mdr=%h lat=%0d want 1 %h 3", done, mdr, lat, e.mdr);
    end
    step();
  endtask

  task automatic test_ignore_ack();
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    IorD = 1'b1;
    repeat (3) step();
    mem_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ir !== m_ir || mdr !== m_mdr) begin
      errors++;
      $display("FAIL idle_ack busy=%b done=%b ir=%h mdr=%h", busy, done, ir, mdr);
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl[6];
    int   lat;
    logic hold;
    exp_t e;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 32'h1111_1111, 1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h204, 32'h0, 32'h0, 32'h2222_2222, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0, 32'h3333_3333, 2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h206, 32'h0, 32'h0, 32'h9999_9999, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h304, 32'h4444_4444, 32'h5555_5555, 3};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h308, 32'h0, 32'h6666_6666, 1};
    foreach (tbl[i]) begin
      drive_access(tbl[i].iord, tbl[i].mw, tbl[i].irw, tbl[i].pv,
                   tbl[i].av, tbl[i].wd, tbl[i].rd, tbl[i].w, lat, hold);
      e = sbq.pop_front();
      checks++;
      if (fault !== e.flt || done !== !e.flt || ir !== e.ir || mdr !== e.mdr) begin
        errors++;
        $display("FAIL b2b_%0d done=%b fault=%b ir=%h mdr=%h want fault=%b ir=%h mdr=%h",
                 i, done, fault, ir, mdr, e.flt, e.ir, e.mdr);
      end
      checks++;
      if (lat !== (e.flt ? 1 : tbl[i].w + 2) || !hold) begin
        errors++;
        $display("FAIL b2b_timing_%0d lat=%0d hold=%b", i, lat, hold);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b1; pc = 32'h80;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_7777;
    step();
    rst = 1'b0;
    m_ir = '0;
    m_mdr = '0;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || ir !== m_ir || mdr !== m_mdr) begin
      errors++;
      $display("FAIL reset_mid req=%b busy=%b ir=%h mdr=%h want 0", mem_req, busy, ir, mdr);
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ir !== m_ir) begin
      errors++;
      $display("FAIL late_ack done=%b busy=%b ir=%h want 0 0 0", done, busy, ir);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; IorD = 1'b0; MemWrite = 1'b0;
    IRWrite = 1'b0; pc = '0; alu_out = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    m_ir = '0;
    m_mdr = '0;
    step();
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_ignore_ack();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
